// File: rtl/spi_slave_alu.sv
// spi_slave_alu: SPI slave that receives {A,B,OP}, runs an ALU op and shifts {RESULT,FLAGS} back on MISO
module spi_slave_alu #(
    parameter int WIDTH    = 4,
    parameter int OP_WIDTH = 4
) (
    input  logic             clk_arduino,
    input  logic             reset,
    input  logic             MOSI,
    input  logic             CS,
    output logic             MISO,
    output logic [WIDTH-1:0] leds,
    output logic             result_valid,
    output logic             frame_err
);
    localparam int F  = 2*WIDTH + OP_WIDTH;
    localparam int RW = $clog2(F);
    localparam int TW = $clog2(WIDTH + 4);
    localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_SHL = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_SHR = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_MUL = OP_WIDTH'(7);

    typedef enum logic [2:0] {HANDSHAKE, READY, RX, EXEC, TX} state_t;

    state_t                state, state_next;
    logic                  hs_ok;
    logic [F-1:0]          frame;
    logic [RW-1:0]         rx_cnt;
    logic [WIDTH+3:0]      tx_shift;
    logic [TW-1:0]         tx_cnt;
    logic [WIDTH-1:0]      a, b, res;
    logic [OP_WIDTH-1:0]   op;
    logic [WIDTH:0]        sum, diff;
    logic                  z, c, v, e;
    logic                  start, abort, shift_big;

    assign a  = frame[F-1 -: WIDTH];
    assign b  = frame[F-1-WIDTH -: WIDTH];
    assign op = frame[OP_WIDTH-1:0];

    // ALU on the staged frame; only consumed on the EXEC edge
    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        shift_big = int'(b) >= WIDTH;
        e         = op > OP_MUL;
        res = op == OP_ADD ? sum[WIDTH-1:0] :
              op == OP_SUB ? diff[WIDTH-1:0] :
              op == OP_AND ? (a & b) :
              op == OP_OR  ? (a | b) :
              op == OP_XOR ? (a ^ b) :
              op == OP_SHL ? (shift_big ? '0 : a << b) :
              op == OP_SHR ? (shift_big ? '0 : a >> b) :
              op == OP_MUL ? a * b : '0;
        z = res == '0;
        c = op == OP_ADD ? sum[WIDTH] : op == OP_SUB ? diff[WIDTH] : 1'b0;
        v = op == OP_ADD ? (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]) :
            op == OP_SUB ? (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]) : 1'b0;
    end

    // state register
    always_ff @(posedge clk_arduino or negedge reset) begin
        if (!reset) state <= HANDSHAKE;
        else        state <= state_next;
    end

    // next-state logic; CS high only aborts once a frame has started
    always_comb begin
        state_next = state;
        start      = !CS && hs_ok && state == READY;
        abort      = CS && (state == RX || state == EXEC || state == TX);
        case (state)
            HANDSHAKE: state_next = (!CS && MOSI) ? READY : HANDSHAKE;
            READY:     state_next = start ? RX : READY;
            RX:        state_next = abort ? READY : (rx_cnt == '0 ? EXEC : RX);
            EXEC:      state_next = abort ? READY : TX;
            TX:        state_next = (abort || tx_cnt == '0) ? READY : TX;
            default:   state_next = HANDSHAKE;
        endcase
    end

    // datapath: frame capture, result load, serial response and status pulses
    always_ff @(posedge clk_arduino or negedge reset) begin
        if (!reset) begin
            hs_ok        <= 1'b0;
            frame        <= '0;
            rx_cnt       <= '0;
            tx_shift     <= '0;
            tx_cnt       <= '0;
            MISO         <= 1'b0;
            leds         <= '0;
            result_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            frame_err    <= 1'b0;
            if (abort) begin
                MISO      <= 1'b1;
                frame_err <= 1'b1;
            end else begin
                case (state)
                    HANDSHAKE: if (!CS && MOSI) begin
                        hs_ok <= 1'b1;
                        MISO  <= 1'b1;
                    end
                    READY: if (start) begin
                        frame  <= {{(F-1){1'b0}}, MOSI};
                        rx_cnt <= RW'(F - 2);
                        MISO   <= 1'b0;
                    end
                    RX: begin
                        frame  <= {frame[F-2:0], MOSI};
                        rx_cnt <= rx_cnt - RW'(1);
                    end
                    EXEC: begin
                        tx_shift <= {res, z, c, v, e};
                        leds     <= res;
                        MISO     <= res[WIDTH-1];
                        tx_cnt   <= TW'(WIDTH + 3);
                    end
                    TX: if (tx_cnt != '0) begin
                        MISO     <= tx_shift[WIDTH+2];
                        tx_shift <= tx_shift << 1;
                        tx_cnt   <= tx_cnt - TW'(1);
                    end else begin
                        MISO         <= 1'b1;
                        result_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_alu.sv
// tb_spi_slave_alu: randomized scoreboard bench for spi_slave_alu
module tb_spi_slave_alu;
    localparam int W   = 4;
    localparam int OPW = 4;
    localparam int F   = 2*W + OPW;

    logic           clk = 1'b0;
    logic           reset, MOSI, CS, MISO, result_valid, frame_err;
    logic [W-1:0]   leds;
    logic [W+3:0]   exp_q[$];
    logic [W+3:0]   hist;
    int             total = 0, bad = 0, err_seen = 0, err_exp = 0;

    spi_slave_alu #(.WIDTH(W), .OP_WIDTH(OPW)) dut (
        .clk_arduino(clk), .reset(reset), .MOSI(MOSI), .CS(CS),
        .MISO(MISO), .leds(leds), .result_valid(result_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W+3:0] model(input int a, input int b, input int op);
        int m = 1 << W, h = 1 << (W-1), r = 0, sa, sb, s;
        logic c = 1'b0, v = 1'b0, e = 1'b0;
        sa = a >= h ? a - m : a;
        sb = b >= h ? b - m : b;
        case (op)
            0: begin r = a + b; c = r >= m; s = sa + sb; v = s >= h || s < -h; end
            1: begin r = a - b; c = a < b; s = sa - sb; v = s >= h || s < -h; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = b >= W ? 0 : a << b;
            6: r = b >= W ? 0 : a >> b;
            7: r = a * b;
            default: e = 1'b1;
        endcase
        r = ((r % m) + m) % m;
        return {r[W-1:0], r == 0, c, v, e};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic step(input logic c, input logic m);
        CS = c;
        MOSI = m;
        @(negedge clk);
    endtask

    task automatic send_bits(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OPW-1:0] op, input int n);
        logic [F-1:0] fr;
        fr = {a, b, op};
        for (int i = 0; i < n; i++) step(1'b0, i < F ? fr[F-1-i] : 1'($urandom % 2));
    endtask

    task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OPW-1:0] op);
        exp_q.push_back(model(a, b, op));
        send_bits(a, b, op, F + W + 5);
    endtask

    // monitor: on each result_valid, the previous W+4 MISO samples form the response
    always @(negedge clk) begin
        logic [W+3:0] ex;
        if (result_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got valid with empty queue");
            end else begin
                ex = exp_q.pop_front();
                check("miso_stream", hist, ex);
                check("leds", leds, ex[W+3:4]);
                check("miso_ack_after_tx", MISO, 1);
            end
        end
        if (frame_err) err_seen++;
        hist = {hist[W+2:0], MISO};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        CS = 1'b1;
        MOSI = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_miso", MISO, 0);
        check("rst_leds", leds, 0);
        check("rst_valid", result_valid, 0);
        check("rst_err", frame_err, 0);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            check("hs_wait_miso", MISO, 0);
        end
        step(1'b0, 1'b1);
        check("hs_ack", MISO, 1);
        step(1'b1, 1'b0);
        check("ready_idle_ack", MISO, 1);
        send_frame(4'd3, 4'd5, 4'd0);
        send_frame(4'd2, 4'd5, 4'd1);
        send_frame(4'd12, 4'd10, 4'd2);
        send_frame(4'd15, 4'd15, 4'd15);
        send_frame(4'd9, 4'd3, 4'd7);
        send_bits(4'd1, 4'd2, 4'd0, 6);
        step(1'b1, 1'b0);
        err_exp++;
        check("abort_rx_err", frame_err, 1);
        check("abort_rx_miso", MISO, 1);
        check("abort_rx_leds", leds, 11);
        step(1'b1, 1'b0);
        check("abort_err_pulse", frame_err, 0);
        send_frame(4'd6, 4'd7, 4'd3);
        send_bits(4'd5, 4'd5, 4'd0, F + 3);
        step(1'b1, 1'b0);
        err_exp++;
        check("abort_tx_err", frame_err, 1);
        check("abort_tx_miso", MISO, 1);
        check("abort_tx_leds", leds, 10);
        for (int k = 0; k < 40; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) step(1'b1, 1'($urandom % 2));
            send_frame(W'($urandom), W'($urandom), OPW'($urandom));
        end
        send_bits(4'd7, 4'd4, 4'd5, F + 4);
        #2 reset = 1'b0;
        #1;
        check("midtx_rst_miso", MISO, 0);
        check("midtx_rst_leds", leds, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < F + W + 5; i++) begin
            step(1'b0, 1'b0);
            check("no_hs_miso", MISO, 0);
        end
        repeat (3) step(1'b1, 1'b0);
        check("queue_empty", exp_q.size(), 0);
        check("frame_err_count", err_seen, err_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
